// File: rtl/serial_adder_ctrl_if.sv
// Start/busy/done handshake and operand/result bus for serial_adder_ctrl.
// Sub exists only when SERIAL_ADD_SUB_EN is defined.
interface serial_adder_ctrl_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
`ifdef SERIAL_ADD_SUB_EN
  logic             Sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Sum;
  logic             Cout;

`ifdef SERIAL_ADD_SUB_EN
  modport master (output start, A, B, Cin, Sub, input busy, done, Sum, Cout);
  modport slave  (input start, A, B, Cin, Sub, output busy, done, Sum, Cout);
`else
  modport master (output start, A, B, Cin, input busy, done, Sum, Cout);
  modport slave  (input start, A, B, Cin, output busy, done, Sum, Cout);
`endif
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full adder (two half adders + OR) stepped LSB-first over WIDTH cycles.
// Optional macro SERIAL_ADD_SUB_EN adds a Sub input for A - B via ~B and carry-in 1.
//
// state  | meaning
// S_IDLE | waiting for start
// S_RUN  | one bit pair consumed per edge, busy=1
// S_DONE | Sum/Cout freshly valid, done=1; start here chains the next operation

module halfadder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input logic              clk,
  input logic              rst_n,
  serial_adder_ctrl_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             c_q, c_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] psum_q, psum_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic ha0_s, ha0_c, ha1_s, ha1_c;
  logic bit_s, bit_c;
  logic [WIDTH-1:0] psum_shift;
  logic             b_load_inv;
  logic             c_load;

  halfadder u_ha0 (.a(a_q[0]), .b(b_q[0]), .s(ha0_s), .c(ha0_c));
  halfadder u_ha1 (.a(ha0_s),  .b(c_q),    .s(ha1_s), .c(ha1_c));

  assign bit_s = ha1_s;
  assign bit_c = ha0_c | ha1_c;

  // New sum bit enters at the MSB so after WIDTH shifts bit 0 lands at the LSB.
  generate
    if (WIDTH == 1) begin : g_w1
      assign psum_shift = bit_s;
    end else begin : g_wn
      assign psum_shift = {bit_s, psum_q[WIDTH-1:1]};
    end
  endgenerate

`ifdef SERIAL_ADD_SUB_EN
  assign b_load_inv = bus.Sub;
  assign c_load     = bus.Sub ? 1'b1 : bus.Cin;
`else
  assign b_load_inv = 1'b0;
  assign c_load     = bus.Cin;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    psum_d  = psum_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      S_RUN: begin
        a_d    = a_q >> 1;
        b_d    = b_q >> 1;
        c_d    = bit_c;
        psum_d = psum_shift;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          sum_d   = psum_shift;
          cout_d  = bit_c;
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        if (bus.start) begin
          a_d     = bus.A;
          b_d     = b_load_inv ? ~bus.B : bus.B;
          c_d     = c_load;
          cnt_d   = '0;
          state_d = S_RUN;
          busy_d  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      psum_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      psum_q  <= psum_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.Sum  = sum_q;
  assign bus.Cout = cout_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: directed cases plus random operations
// against an arithmetic reference ({Cout,Sum} = A + B + Cin, or A + ~B + 1 for Sub).
module tb_serial_adder_ctrl;
  localparam int W = 8;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  logic [W-1:0] prev_sum;
  logic         prev_cout;

  serial_adder_ctrl_if #(.WIDTH(W)) bus ();

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic cin, input logic sub);
    if (sub) return {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
    return {1'b0, a} + {1'b0, b} + (W+1)'(cin);
  endfunction

  task automatic drive(input logic st, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic sub);
    bus.start = st;
    bus.A     = a;
    bus.B     = b;
    bus.Cin   = cin;
`ifdef SERIAL_ADD_SUB_EN
    bus.Sub   = sub;
`else
    if (sub) $display("note: subtract requested without SERIAL_ADD_SUB_EN");
`endif
  endtask

  // Called at a negedge; drives start now (works from IDLE or from the DONE cycle)
  // and returns at the negedge where done is observed.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic sub, input int glitch_at);
    logic [W:0] exp;
    bit seen;
    int lat;
    exp  = model(a, b, cin, sub);
    seen = 0;
    lat  = 0;
    drive(1'b1, a, b, cin, sub);
    @(negedge clk);
    drive(1'b0, W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
    check("busy_after_start", 32'(bus.busy), 1);
    check("done_after_start", 32'(bus.done), 0);
    for (int i = 1; i <= W + 4 && !seen; i++) begin
      if (i == glitch_at) begin
        bus.start = 1'b1;
        bus.A     = 8'hAA;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      if (bus.done) begin
        seen = 1;
        lat  = i;
      end else begin
        check("busy_run", 32'(bus.busy), 1);
        check("sum_hold", 32'(bus.Sum), 32'(prev_sum));
        check("cout_hold", 32'(bus.Cout), 32'(prev_cout));
      end
    end
    bus.start = 1'b0;
    if (!seen) begin
      check("done_timeout", 0, 1);
    end else begin
      check("latency", lat, W);
      check("busy_done", 32'(bus.busy), 0);
      check("sum", 32'(bus.Sum), 32'(exp[W-1:0]));
      check("cout", 32'(bus.Cout), 32'(exp[W]));
    end
    prev_sum  = exp[W-1:0];
    prev_cout = exp[W];
  endtask

  task automatic idle_gap();
    @(negedge clk);
    check("done_single", 32'(bus.done), 0);
    check("busy_idle", 32'(bus.busy), 0);
    check("sum_held", 32'(bus.Sum), 32'(prev_sum));
    check("cout_held", 32'(bus.Cout), 32'(prev_cout));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    prev_sum  = '0;
    prev_cout = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_sum", 32'(bus.Sum), 0);
    check("rst_cout", 32'(bus.Cout), 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(8'h12, 8'h34, 1'b0, 1'b0, 0);
    idle_gap();
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, 0);
    idle_gap();
    run_op(8'hFF, 8'hFF, 1'b1, 1'b0, 0);
    idle_gap();

    // Earlier result must hold through RUN; a start pulse mid-RUN must be ignored.
    run_op(8'h0F, 8'h01, 1'b0, 1'b0, 3);
    idle_gap();

    run_op(8'h01, 8'h02, 1'b0, 1'b0, 0);
    run_op(8'h80, 8'h80, 1'b0, 1'b0, 0);
    idle_gap();

    drive(1'b1, 8'h3C, 8'h5A, 1'b1, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(bus.busy), 0);
    check("midrst_done", 32'(bus.done), 0);
    check("midrst_sum", 32'(bus.Sum), 0);
    check("midrst_cout", 32'(bus.Cout), 0);
    prev_sum  = '0;
    prev_cout = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < W + 2; i++) begin
      @(negedge clk);
      check("midrst_no_done", 32'(bus.done), 0);
    end
    run_op(8'h21, 8'h43, 1'b1, 1'b0, 0);
    idle_gap();

`ifdef SERIAL_ADD_SUB_EN
    run_op(8'h05, 8'h07, 1'b0, 1'b1, 0);
    idle_gap();
    run_op(8'h07, 8'h05, 1'b1, 1'b1, 0);
    idle_gap();
`endif

    for (int n = 0; n < 40; n++) begin
      logic sub;
`ifdef SERIAL_ADD_SUB_EN
      sub = 1'($urandom);
`else
      sub = 1'b0;
`endif
      run_op(W'($urandom), W'($urandom), 1'($urandom), sub,
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, W - 1)) : 0);
      if ($urandom_range(0, 1) == 1) idle_gap();
    end
    idle_gap();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
